// File: rtl/ps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard event path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2kb_pkg;

  // Set-2 prefix bytes and the keyboard's error/overrun codes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_ERR_00     = 8'h00;
  localparam logic [7:0] PS2_ERR_FF     = 8'hFF;

  // One complete key event as stored in the FIFO
  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  localparam int KEY_EVENT_W = $bits(key_event_t);

  // Capture handshake with the receiver's holding register
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } cap_state_t;

  // Bytes the keyboard sends to report an internal error or buffer overrun
  function automatic logic is_err_code(input logic [7:0] b);
    return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2kb_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Latency: a write is visible at rdata the cycle after push.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle; rdata is zero when empty.
module ps2kb_sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                   DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop vacates the head slot, which is exactly wr_ptr
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by empty
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at 2**DEPTH_LOG2; level tracks occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2kb_event_fifo.sv
// PS/2 set-2 byte capture, prefix folding and key-event buffering (optional KEY_EVENT_REPEAT_FILTER_EN drops typematic repeats).
// Latency: event visible on event_* the cycle after the byte is captured; clear_keycode pulses the cycle after capture.
// Backpressure: host stalls with event_ready=0; events arriving while full are dropped and flagged in sticky overflow.
module ps2kb_event_fifo
  import ps2kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  irq,
  input  logic [7:0]            keycode,
  output logic                  clear_keycode,
  output logic                  event_valid,
  output logic [7:0]            event_code,
  output logic                  event_break,
  output logic                  event_extended,
  input  logic                  event_ready,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  cap_state_t state;
  cap_state_t state_next;
  logic       ext_flag;
  logic       brk_flag;
  logic       capture;
  logic       is_ext;
  logic       is_brk;
  logic       is_err;
  logic       repeat_hit;
  logic       push_req;
  logic       pop_eff;
  logic       push_ok;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  key_event_t cand;
  key_event_t head;

  // A byte is taken only in IDLE, so the held irq level cannot re-trigger
  assign capture = (state == ST_IDLE) & irq;
  assign is_ext  = (keycode == PS2_PREFIX_EXT);
  assign is_brk  = (keycode == PS2_PREFIX_BRK);
  assign is_err  = is_err_code(keycode);
  assign cand    = '{extended: ext_flag, brk: brk_flag, code: keycode};

  assign push_req = capture & ~is_ext & ~is_brk & ~is_err & ~repeat_hit;
  assign pop_eff  = event_ready & event_valid;
  assign push_ok  = push_req & (~fifo_full | pop_eff);
  assign drop     = push_req & fifo_full & ~pop_eff;

`ifdef KEY_EVENT_REPEAT_FILTER_EN
  logic       last_vld;
  key_event_t last_evt;

  // Typematic repeat: a make identical to the last accepted event
  assign repeat_hit = last_vld & ~cand.brk & (last_evt == cand);

  // Remember the last event that actually entered the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_vld <= 1'b0;
      last_evt <= '0;
    end else if (push_ok) begin
      last_vld <= 1'b1;
      last_evt <= cand;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // Capture FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: acknowledge once, then wait for the receiver to drop irq
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (irq) state_next = ST_ACK;
      ST_ACK:      state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!irq) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Registered one-cycle acknowledge, coincides with the ACK state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) clear_keycode <= 1'b0;
    else       clear_keycode <= capture;
  end

  // Prefix flags accumulate until any non-prefix byte (pushed, dropped or discarded)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (capture) begin
      if (is_ext) begin
        ext_flag <= 1'b1;
      end else if (is_brk) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  ps2kb_sync_fifo #(
    .WIDTH      (KEY_EVENT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .wdata (cand),
    .pop   (event_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign event_valid    = ~fifo_empty;
  assign event_code     = head.code;
  assign event_break    = head.brk;
  assign event_extended = head.extended;

endmodule

// File: doc/ps2kb_event_fifo.md
Name: ps2kb_event_fifo

Overview:
- Sits directly downstream of the PS/2 keyboard receiver.
- Consumes its irq/keycode pair, acknowledges each byte by pulsing clear_keycode, and folds set-2 prefix bytes (0xE0 extended, 0xF0 break) into flags.
- Buffers complete key events in a first-word-fall-through FIFO behind a valid/ready port for the host/CPU side.
- Decouples host read latency from the receiver's single-byte holding register, so back-to-back scancodes no longer overrun.

Parameters:
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 entries (legal range 1..6).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-high
- irq  input  1  receiver has a byte in keycode; level, held until cleared
- keycode  input  8  received scancode byte
- clear_keycode  output  1  one-cycle acknowledge to receiver
- event_valid  output  1  FIFO head holds an event
- event_code  output  8  head event scancode (prefixes stripped)
- event_break  output  1  head event is a release (0xF0 seen)
- event_extended  output  1  head event is extended (0xE0 seen)
- event_ready  input  1  host consumes head when event_valid&event_ready
- overflow  output  1  sticky, an event was dropped because FIFO full
- clear_overflow  input  1  clears overflow
- fifo_level  output  DEPTH_LOG2+1  number of stored events

Behaviour:
- Reset (async, any time, including mid-byte or mid-prefix sequence):
  - Outputs: clear_keycode=0, event_valid=0, event_code/event_break/event_extended=0, overflow=0, fifo_level=0.
  - Internal: ext/brk prefix flags cleared, FIFO pointers zeroed, FSM to IDLE.
- Capture FSM: IDLE -> ACK -> WAIT_LOW -> IDLE.
  - IDLE: on irq=1, process keycode this cycle (see classification), go to ACK.
  - ACK: clear_keycode=1 for exactly this one cycle (registered output), go to WAIT_LOW.
  - WAIT_LOW: stay until irq=0, then IDLE. irq is ignored in ACK and WAIT_LOW, so one byte is never processed twice.
- Classification of the captured byte:
  - 0xE0: ext_flag<=1, no push.
  - 0xF0: brk_flag<=1, no push.
  - 0x00 or 0xFF (keyboard error/overrun codes): discard, clear both flags, no push.
  - Any other byte: push {ext_flag, brk_flag, keycode}, then clear both flags.
  - Prefix order E0,F0 or F0,E0: both flags accumulate into one event.
- FIFO:
  - First-word-fall-through: event_valid = (level != 0).
  - Event fields are 0 when empty (gated).
  - Push in capture cycle N makes event_valid=1 with the new data at cycle N+1 when the FIFO was empty.
  - Pop when event_valid&event_ready; head advances next cycle.
  - Push and pop in the same cycle: level unchanged; allowed even when full (pop frees the slot first).
  - Push while full with no pop: event dropped, overflow<=1, flags still cleared.
  - event_ready while empty: ignored.
- Pointers wrap modulo 2**DEPTH_LOG2; level is DEPTH_LOG2+1 bits and never exceeds 2**DEPTH_LOG2.
- overflow: set has priority over clear_overflow in the same cycle.

Optional Feature:
- Macro KEY_EVENT_REPEAT_FILTER_EN.
- Defined:
  - Keeps a register of the last pushed event ({ext, brk, code} plus valid bit; cleared on reset).
  - A make event (brk=0) identical to the last pushed event is not pushed (typematic repeats suppressed).
  - Any pushed break event, or any pushed different make event, updates the register; a break clears the repeat match.
  - Filtered events never count as overflow.
- Undefined: every classified event is pushed; no extra registers.

Decomposition:
- Shared package ps2kb_pkg:
  - Constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_ERR_00=8'h00, PS2_ERR_FF=8'hFF.
  - typedef key_event_t packed struct {logic extended; logic brk; logic [7:0] code}.
  - FSM state enum.
- One sub-module: ps2kb_sync_fifo, a generic FWFT FIFO parameterised by width and DEPTH_LOG2, with push/pop/full/empty/level. The top module holds the FSM, prefix flags, overflow and optional filter.

Test Plan:
- Make code: irq with keycode 0x1C -> clear_keycode one-cycle pulse, next cycle event_valid=1, code=0x1C, brk=0, ext=0, fifo_level=1; pop with event_ready -> event_valid=0.
- Break sequence: 0xF0 then 0x1C -> exactly one event {code 0x1C, brk 1, ext 0}; no event after the 0xF0 alone.
- Extended break sequence: 0xE0, 0xF0, 0x75 -> one event {0x75, brk 1, ext 1}; the following 0x75 gives {0x75, 0, 0}; error byte 0xFF mid-prefix clears flags and yields no event.
- Overflow (DEPTH_LOG2=3): 9 make codes 0x01..0x09 with event_ready=0 -> fifo_level=8, overflow=1, head 0x01. Then:
  - Drain yields 0x01..0x08.
  - Simultaneous push of 0x0A and pop at full keeps level 8, overflow stays 1 until clear_overflow.
- irq held high for 20 cycles after clear_keycode -> only one event pushed; reset asserted between 0xE0 and 0x75 -> after reset, 0x75 yields ext=0 and all outputs return to reset values.
- With KEY_EVENT_REPEAT_FILTER_EN: 0x1C,0x1C,0x1C,F0 1C,0x1C -> three events: make 1C, break 1C, make 1C. Without the macro -> five events.
